// File: rtl/memory_stage_pkg.sv
// Shared MIPS pipeline definitions: EX/MEM and MEM/WB field positions, word widths and
// data-memory fault cause encodings. The execution stage decodes the same words with
// these constants.
package memory_stage_pkg;

  // EX/MEM pipeline word layout
  localparam int unsigned ExMemW           = 75;
  localparam int unsigned ExMemAluLo       = 0;
  localparam int unsigned ExMemAluHi       = 31;
  localparam int unsigned ExMemStoreLo     = 32;
  localparam int unsigned ExMemStoreHi     = 63;
  localparam int unsigned ExMemDestLo      = 64;
  localparam int unsigned ExMemDestHi      = 68;
  localparam int unsigned ExMemZeroBit     = 69;
  localparam int unsigned ExMemOverflowBit = 70;
  localparam int unsigned ExMemMemReadBit  = 71;
  localparam int unsigned ExMemMemToRegBit = 72;
  localparam int unsigned ExMemMemWriteBit = 73;
  localparam int unsigned ExMemRegWriteBit = 74;

  // MEM/WB pipeline word layout
  localparam int unsigned MemWbW           = 38;
  localparam int unsigned MemWbResultLo    = 0;
  localparam int unsigned MemWbResultHi    = 31;
  localparam int unsigned MemWbDestLo      = 32;
  localparam int unsigned MemWbDestHi      = 36;
  localparam int unsigned MemWbRegWriteBit = 37;

  typedef enum logic [1:0] {
    CauseNone       = 2'b00,
    CauseMisaligned = 2'b01,
    CauseRange      = 2'b10,
    CauseConflict   = 2'b11
  } fault_cause_e;

  // Resolve simultaneous fault conditions: conflict > misaligned > out-of-range.
  function automatic fault_cause_e fault_cause_sel(input logic conflict,
                                                   input logic misaligned,
                                                   input logic out_of_range);
    fault_cause_e cause;
    cause = CauseNone;
    if (conflict) begin
      cause = CauseConflict;
    end else if (misaligned) begin
      cause = CauseMisaligned;
    end else if (out_of_range) begin
      cause = CauseRange;
    end
    return cause;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Word-addressed data memory for the MEM stage: synchronous write, asynchronous read,
// plus a second asynchronous read port for debug. Contents are never reset.
module memory_stage_data_memory #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [31:0]       dbg_data_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Write port: a store lands on the rising edge and is visible to the next read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Checks each access for faults, performs stores,
// selects load data or ALU result and registers the MEM/WB word.
// Optional build macro: MEM_PERF_CNT_EN adds saturating load/store counters; without it
// load_count and store_count are tied to zero.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ExMemW-1:0] EXMEMReg,
  output logic [MemWbW-1:0] MEMWBReg,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data,
  output logic              mem_fault,
  output logic [1:0]        fault_cause,
  output logic [31:0]       fault_addr,
  output logic [15:0]       load_count,
  output logic [15:0]       store_count
);

  // EX/MEM field extraction
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest;
  logic        overflow;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        reg_write;
  logic        unused_zero;

  assign alu_result  = EXMEMReg[ExMemAluHi:ExMemAluLo];
  assign store_data  = EXMEMReg[ExMemStoreHi:ExMemStoreLo];
  assign dest        = EXMEMReg[ExMemDestHi:ExMemDestLo];
  assign overflow    = EXMEMReg[ExMemOverflowBit];
  assign mem_read    = EXMEMReg[ExMemMemReadBit];
  assign mem_to_reg  = EXMEMReg[ExMemMemToRegBit];
  assign mem_write   = EXMEMReg[ExMemMemWriteBit];
  assign reg_write   = EXMEMReg[ExMemRegWriteBit];
  // Branches resolve upstream; the zero flag has no use here.
  assign unused_zero = EXMEMReg[ExMemZeroBit];

  // Fault detection
  logic        access;
  logic        misaligned;
  logic        out_of_range;
  logic        conflict;
  logic        fault_now;
  logic [31:0] addr_hi;

  assign access       = mem_read | mem_write;
  assign addr_hi      = alu_result >> (ADDR_W + 2);
  assign misaligned   = access & (|alu_result[1:0]);
  assign out_of_range = access & (|addr_hi);
  assign conflict     = mem_read & mem_write;
  assign fault_now    = misaligned | out_of_range | conflict;

  // Data memory
  logic [ADDR_W-1:0] word_idx;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  assign word_idx = alu_result[ADDR_W+1:2];
  assign mem_we   = mem_write & ~fault_now & ~overflow;

  memory_stage_data_memory #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_data_memory (
    .clk_i      (clk),
    .we_i       (mem_we),
    .addr_i     (word_idx),
    .wdata_i    (store_data),
    .rdata_o    (mem_rdata),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Result select and MEM/WB next state; $zero never marked as written so forwarding
  // cannot source it.
  logic [31:0]       rdata;
  logic [31:0]       result;
  logic [MemWbW-1:0] memwb_d;
  logic [MemWbW-1:0] memwb_q;

  always_comb begin
    rdata  = fault_now ? 32'h0 : mem_rdata;
    result = mem_to_reg ? rdata : alu_result;
    memwb_d = '0;
    memwb_d[MemWbResultHi:MemWbResultLo] = result;
    memwb_d[MemWbDestHi:MemWbDestLo]     = dest;
    memwb_d[MemWbRegWriteBit]            = reg_write & ~overflow & ~fault_now & (dest != 5'd0);
  end

  // MEM/WB register, updated every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  assign MEMWBReg = memwb_q;

  // Sticky fault capture: only the first fault after reset is recorded.
  logic         mem_fault_d;
  logic         mem_fault_q;
  fault_cause_e fault_cause_d;
  fault_cause_e fault_cause_q;
  logic [31:0]  fault_addr_d;
  logic [31:0]  fault_addr_q;

  // Next-state for the fault record.
  always_comb begin
    mem_fault_d   = mem_fault_q;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    if (fault_now && !mem_fault_q) begin
      mem_fault_d   = 1'b1;
      fault_cause_d = fault_cause_sel(conflict, misaligned, out_of_range);
      fault_addr_d  = alu_result;
    end
  end

  // Fault record state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_fault_q   <= 1'b0;
      fault_cause_q <= CauseNone;
      fault_addr_q  <= 32'h0;
    end else begin
      mem_fault_q   <= mem_fault_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign mem_fault   = mem_fault_q;
  assign fault_cause = fault_cause_q;
  assign fault_addr  = fault_addr_q;

`ifdef MEM_PERF_CNT_EN
  logic [15:0] load_cnt_d;
  logic [15:0] load_cnt_q;
  logic [15:0] store_cnt_d;
  logic [15:0] store_cnt_q;

  // Saturating counters of retired loads and performed stores.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (mem_read && !fault_now && (load_cnt_q != 16'hFFFF)) begin
      load_cnt_d = load_cnt_q + 16'd1;
    end
    if (mem_we && (store_cnt_q != 16'hFFFF)) begin
      store_cnt_d = store_cnt_q + 16'd1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= 16'h0;
      store_cnt_q <= 16'h0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
`else
  assign load_count  = 16'h0;
  assign store_count = 16'h0;
`endif

endmodule
